div_ctrl: RTL and testbench

Sequencing controller between the EX stage of the 16-bit pipeline and the shared multi-cycle divide unit. It accepts a divide request, registers and holds the operands, drives start/annul toward the divider, and stalls the pipeline until the result returns. It then splits the result into quotient and remainder and handles flush, divide-by-zero and a watchdog timeout. Sits beside the divider in the EX stage; outputs feed the HI/LO write path and hazard unit.

---
 rtl/div_ctrl_pkg.sv | 27 ++
 rtl/div_ctrl.sv | 117 +++++++++++
 tb/tb_div_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// div_ctrl_pkg: shared encodings and defaults for the divide sequencer. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package div_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    localparam int DEF_TIMEOUT      = 32;
    localparam int DEF_FLUSH_CYCLES = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : div_ctrl_pkg

`default_nettype wire

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl: EX-stage sequencer for the shared multi-cycle divide unit. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        signed_i,
    input  logic [15:0] op1_i,
    input  logic [15:0] op2_i,
    input  logic        flush_i,
    input  logic [31:0] div_result_i,
    input  logic        div_ready_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [15:0] div_op1_o,
    output logic [15:0] div_op2_o,
    output logic        stall_o,
    output logic        result_valid_o,
    output logic [15:0] quot_o,
    output logic [15:0] rem_o,
    output logic        dbz_o,
    output logic        timeout_o
);

    localparam int CNT_W = $clog2(max_int(TIMEOUT, FLUSH_CYCLES) + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               dbz_flag;

    // One counter serves as the BUSY watchdog and the FLUSH hold-off timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            div_start_o  <= DIV_STOP;
            div_annul_o  <= 1'b0;
            div_signed_o <= 1'b0;
            div_op1_o    <= '0;
            div_op2_o    <= '0;
            quot_o       <= '0;
            rem_o        <= '0;
            dbz_flag     <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            div_annul_o <= 1'b0;
            timeout_o   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_i && !flush_i) begin
                        div_signed_o <= signed_i;
                        div_op1_o    <= op1_i;
                        div_op2_o    <= op2_i;
                        div_start_o  <= DIV_START;
                        dbz_flag     <= (op2_i == 16'd0);
                        cnt          <= '0;
                        state        <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt + 1'b1;
                    // Flush wins over a coincident ready: the result belongs to a killed instruction.
                    if (flush_i) begin
                        div_start_o <= DIV_STOP;
                        div_annul_o <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_FLUSH;
                    end else if (div_ready_i) begin
                        quot_o      <= div_result_i[15:0];
                        rem_o       <= div_result_i[31:16];
                        div_start_o <= DIV_STOP;
                        state       <= ST_DONE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        timeout_o   <= 1'b1;
                        div_annul_o <= 1'b1;
                        div_start_o <= DIV_STOP;
                        cnt         <= '0;
                        state       <= ST_FLUSH;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                ST_FLUSH: begin
                    if (cnt == CNT_W'(FLUSH_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    div_start_o <= DIV_STOP;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign result_valid_o = (state == ST_DONE) && !flush_i;
    assign dbz_o          = dbz_flag;
    assign stall_o        = ((state == ST_IDLE) && req_i && !flush_i)
                          || (state == ST_BUSY)
                          || ((state == ST_FLUSH) && req_i);

endmodule : div_ctrl

`default_nettype wire

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl: self-checking bench for div_ctrl with a behavioural divider. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        sgn = 1'b0;
    logic [15:0] op1 = '0;
    logic [15:0] op2 = '0;
    logic        flush = 1'b0;
    logic [31:0] div_result;
    logic        div_ready;

    logic        div_start, div_annul, div_signed;
    logic [15:0] div_op1, div_op2, quot, rem;
    logic        stall, result_valid, dbz, timeout;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] last_q = '0;
    logic        hang = 1'b0;
    int          since;

    always #5 clk = ~clk;

    div_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req),
        .signed_i       (sgn),
        .op1_i          (op1),
        .op2_i          (op2),
        .flush_i        (flush),
        .div_result_i   (div_result),
        .div_ready_i    (div_ready),
        .div_start_o    (div_start),
        .div_annul_o    (div_annul),
        .div_signed_o   (div_signed),
        .div_op1_o      (div_op1),
        .div_op2_o      (div_op2),
        .stall_o        (stall),
        .result_valid_o (result_valid),
        .quot_o         (quot),
        .rem_o          (rem),
        .dbz_o          (dbz),
        .timeout_o      (timeout)
    );

    // Arithmetic meaning of a divide: {remainder, quotient}, zero divisor gives zeros.
    function automatic logic [31:0] ref_div(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [15:0] q, r;
        if (b == 16'd0) begin
            q = '0;
            r = '0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Team divider: ready 18 edges after start for a nonzero divisor, 2 for zero.
    always @(posedge clk or negedge rst) begin
        if (!rst)           since <= 0;
        else if (div_start) since <= since + 1;
        else                since <= 0;
    end
    assign div_ready  = !hang && div_start && (since == ((div_op2 == 16'd0) ? 2 : 18));
    assign div_result = ref_div(div_op1, div_op2, div_signed);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Entered 1 time unit after a rising edge; that cycle is cycle 0 of the request.
    task automatic do_div(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic [15:0] eq, input logic [15:0] er, input int flush_at);
        int lat;
        int n_end;
        lat   = (b == 16'd0) ? 4 : 20;
        n_end = (flush_at >= 0) ? flush_at + 3 : lat;
        req = 1'b1; op1 = a; op2 = b; sgn = s; flush = 1'b0;
        for (int c = 0; c <= n_end; c++) begin
            if (flush_at >= 0) begin
                flush = (c == flush_at);
                if (c > flush_at) req = 1'b0;
            end
            @(negedge clk);
            check_eq("timeout_idle", timeout, 0);
            if (c == 0) check_eq("quot_hold", quot, last_q);
            if (flush_at < 0) begin
                check_eq("stall", stall, (c < lat));
                check_eq("valid", result_valid, (c == lat));
                check_eq("annul", div_annul, 0);
                if (c >= 1) check_eq("start", div_start, (c < lat));
                if (c == 1) check_eq("ops", {div_signed, div_op1, div_op2}, {s, a, b});
                if (c == lat) begin
                    check_eq("quot", quot, eq);
                    check_eq("rem", rem, er);
                    check_eq("dbz", dbz, (b == 16'd0));
                    last_q = eq;
                end
            end else begin
                check_eq("stall_fl", stall, (c <= flush_at));
                check_eq("valid_fl", result_valid, 0);
                check_eq("annul_fl", div_annul, (c == flush_at + 1));
                if (c > flush_at) check_eq("start_fl", div_start, 0);
            end
            @(posedge clk);
            #1;
        end
        req = 1'b0; flush = 1'b0;
    endtask

    task automatic do_timeout(input logic [15:0] a, input logic [15:0] b);
        hang = 1'b1;
        req = 1'b1; op1 = a; op2 = b; sgn = 1'b0; flush = 1'b0;
        for (int c = 0; c <= 35; c++) begin
            if (c == 34) req = 1'b0;
            @(negedge clk);
            check_eq("tmo_pulse", timeout, (c == 33));
            check_eq("tmo_annul", div_annul, (c == 33));
            check_eq("tmo_stall", stall, (c < 34));
            check_eq("tmo_valid", result_valid, 0);
            if (c >= 33) check_eq("tmo_start", div_start, 0);
            @(posedge clk);
            #1;
        end
        hang = 1'b0;
    endtask

    initial begin
        logic [15:0] a, b;
        logic        s;
        logic [31:0] rq;
        int          lat;

        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_state",
                 {div_start, div_annul, div_signed, div_op1, div_op2, stall,
                  result_valid, quot, rem, dbz, timeout}, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        do_div(16'd100, 16'd7, 1'b0, 16'd14, 16'd2, -1);
        idle(1);
        do_div(16'hFF9C, 16'd7, 1'b1, 16'hFFF2, 16'hFFFE, -1);
        idle(2);
        do_div(16'h1234, 16'd0, 1'b0, 16'd0, 16'd0, -1);
        do_div(16'd9, 16'd3, 1'b0, 16'd3, 16'd0, -1);
        idle(1);
        do_div(16'd1000, 16'd3, 1'b0, 16'd0, 16'd0, 8);
        do_div(16'd50, 16'd5, 1'b0, 16'd10, 16'd0, -1);
        idle(1);
        do_timeout(16'd77, 16'd5);
        do_div(16'd81, 16'd9, 1'b0, 16'd9, 16'd0, -1);

        // Asynchronous reset in the middle of BUSY.
        req = 1'b1; op1 = 16'h7777; op2 = 16'd5; sgn = 1'b0;
        idle(8);
        req = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_eq("reset_mid",
                 {div_start, div_annul, div_signed, div_op1, div_op2, stall,
                  result_valid, quot, rem, dbz, timeout}, '0);
        last_q = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_div(16'd200, 16'd9, 1'b0, 16'd22, 16'd2, -1);
        do_div(16'd77, 16'd7, 1'b0, 16'd0, 16'd0, 19);
        do_div(16'd77, 16'd7, 1'b0, 16'd11, 16'd0, -1);

        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            if ($urandom_range(0, 2) == 0) b = 16'($urandom_range(1, 20));
            s = 1'($urandom_range(0, 1));
            rq = ref_div(a, b, s);
            lat = (b == 16'd0) ? 4 : 20;
            if ($urandom_range(0, 4) == 0)
                do_div(a, b, s, 16'd0, 16'd0, $urandom_range(1, lat - 1));
            else
                do_div(a, b, s, rq[15:0], rq[31:16], -1);
            idle($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_div_ctrl

`default_nettype wire
